// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle RV32I(M) core on a shared req/ack memory bus
module cpu_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          EXTM     = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_req,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_ack,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_pc,
    output logic        o_retire,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, ir, op_a, op_b, res, npc;
    logic [1:0]  trap_cause, cause_nxt;
    logic [31:0] rf [0:31];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic is_load, is_store, is_m, legal, is_sys;
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_m     = (opcode == OP_REG) && (f7 == 7'b0000001);

    always_comb begin
        legal  = 1'b0;
        is_sys = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:   legal = (f3 == 3'b000);
            OP_BRANCH: legal = (f3[2:1] != 2'b01);
            OP_LOAD:   legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            OP_STORE:  legal = !f3[2] && (f3[1:0] != 2'b11);
            OP_IMM: begin
                if (f3 == 3'b001)      legal = (f7 == 7'b0);
                else if (f3 == 3'b101) legal = (f7 == 7'b0) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
            end
            OP_REG: begin
                if (f7 == 7'b0)             legal = 1'b1;
                else if (f7 == 7'b0100000)  legal = (f3 == 3'b000) || (f3 == 3'b101);
                else if (f7 == 7'b0000001)  legal = (EXTM != 0);
                else                        legal = 1'b0;
            end
            OP_FENCE:  legal = (f3 == 3'b000);
            OP_SYSTEM: begin
                is_sys = (f3 == 3'b000) && (ir[31:21] == 11'b0) && (rs1 == 5'd0) && (rd == 5'd0);
                legal  = is_sys;
            end
            default:   legal = 1'b0;
        endcase
    end

    logic [31:0] b_src, alu_res, m_res, exec_res, tgt, ea, quo, rem;
    logic [63:0] p_ss, p_su, p_uu;
    logic        taken, mem_misal, tgt_misal, sub_op;

    always_comb begin
        b_src   = (opcode == OP_REG) ? op_b : imm_i;
        sub_op  = (opcode == OP_REG) && f7[5];
        alu_res = 32'b0;
        case (f3)
            3'b000: alu_res = sub_op ? op_a - b_src : op_a + b_src;
            3'b001: alu_res = op_a << b_src[4:0];
            3'b010: alu_res = {31'b0, $signed(op_a) < $signed(b_src)};
            3'b011: alu_res = {31'b0, op_a < b_src};
            3'b100: alu_res = op_a ^ b_src;
            3'b101: alu_res = f7[5] ? 32'($signed(op_a) >>> b_src[4:0]) : op_a >> b_src[4:0];
            3'b110: alu_res = op_a | b_src;
            default: alu_res = op_a & b_src;
        endcase

        // low 64 bits of a product are sign-agnostic once the operands are extended
        p_ss = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        p_su = {{32{op_a[31]}}, op_a} * {32'b0, op_b};
        p_uu = {32'b0, op_a} * {32'b0, op_b};
        if (op_b == 32'b0) begin
            quo = 32'hFFFF_FFFF;
            rem = op_a;
        end else if (!f3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'b0;
        end else if (!f3[0]) begin
            quo = 32'($signed(op_a) / $signed(op_b));
            rem = 32'($signed(op_a) % $signed(op_b));
        end else begin
            quo = op_a / op_b;
            rem = op_a % op_b;
        end
        case (f3)
            3'b000: m_res = p_ss[31:0];
            3'b001: m_res = p_ss[63:32];
            3'b010: m_res = p_su[63:32];
            3'b011: m_res = p_uu[63:32];
            3'b100, 3'b101: m_res = quo;
            default: m_res = rem;
        endcase

        case (f3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) < $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a < op_b);
            default: taken = (op_a >= op_b);
        endcase

        ea       = op_a + (is_store ? imm_s : imm_i);
        tgt      = pc + imm_b;
        exec_res = alu_res;
        case (opcode)
            OP_LUI:   exec_res = imm_u;
            OP_AUIPC: exec_res = pc + imm_u;
            OP_JAL: begin
                taken    = 1'b1;
                tgt      = pc + imm_j;
                exec_res = pc + 32'd4;
            end
            OP_JALR: begin
                taken    = 1'b1;
                tgt      = (op_a + imm_i) & ~32'd1;
                exec_res = pc + 32'd4;
            end
            OP_BRANCH: exec_res = 32'b0;
            OP_LOAD, OP_STORE: exec_res = ea;
            OP_REG:   exec_res = (is_m && EXTM != 0) ? m_res : alu_res;
            default:  exec_res = alu_res;
        endcase
        if (opcode != OP_BRANCH && opcode != OP_JAL && opcode != OP_JALR)
            taken = 1'b0;

        mem_misal = (is_load || is_store) &&
                    ((f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00));
        tgt_misal = taken && (tgt[1:0] != 2'b00);
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = trap_cause;
        case (state)
            S_FETCH:  if (i_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    state_nxt = S_HALT;
                    cause_nxt = 2'd0;
                end else if (is_sys) begin
                    state_nxt = S_HALT;
                    cause_nxt = 2'd3;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (mem_misal) begin
                    state_nxt = S_HALT;
                    cause_nxt = 2'd1;
                end else if (tgt_misal) begin
                    state_nxt = S_HALT;
                    cause_nxt = 2'd2;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM:   if (i_ack) state_nxt = S_WB;
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    logic [31:0] lane, load_val, st_data;
    logic [3:0]  st_strb;
    logic        rd_we;

    always_comb begin
        lane = i_rdata >> {res[1:0], 3'b000};
        case (f3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'b0, lane[7:0]};
            3'b101:  load_val = {16'b0, lane[15:0]};
            default: load_val = lane;
        endcase
        case (f3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << res[1:0];
                st_data = {4{op_b[7:0]}};
            end
            2'b01: begin
                st_strb = res[1] ? 4'b1100 : 4'b0011;
                st_data = {2{op_b[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = op_b;
            end
        endcase
    end

    assign rd_we = (opcode != OP_BRANCH) && (opcode != OP_STORE) && (opcode != OP_FENCE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= 32'b0;
            op_a       <= 32'b0;
            op_b       <= 32'b0;
            res        <= 32'b0;
            npc        <= 32'b0;
            trap_cause <= 2'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'b0;
        end else begin
            state      <= state_nxt;
            trap_cause <= cause_nxt;
            case (state)
                S_FETCH:  if (i_ack) ir <= i_rdata;
                S_DECODE: begin
                    op_a <= rf[rs1];
                    op_b <= rf[rs2];
                end
                S_EXEC: begin
                    res <= exec_res;
                    npc <= taken ? tgt : pc + 32'd4;
                end
                S_MEM:    if (i_ack && is_load) res <= load_val;
                S_WB: begin
                    if (rd_we && rd != 5'd0) rf[rd] <= res;
                    pc <= npc;
                end
                default: ;
            endcase
        end
    end

    // reset gates the bus combinationally so a pending request vanishes immediately
    assign o_req        = i_rst_n && (state == S_FETCH || state == S_MEM);
    assign o_we         = o_req && (state == S_MEM) && is_store;
    assign o_addr       = !o_req ? 32'b0 : (state == S_MEM) ? {res[31:2], 2'b00} : {pc[31:2], 2'b00};
    assign o_wstrb      = o_we ? st_strb : 4'b0;
    assign o_wdata      = o_we ? st_data : 32'b0;
    assign o_pc         = pc;
    assign o_retire     = (state == S_WB);
    assign o_trap       = (state == S_HALT);
    assign o_trap_cause = trap_cause;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed self-checking bench for cpu_multicycle
module tb_cpu_multicycle;

    localparam logic [6:0] LUI = 7'b0110111, JALR = 7'b1100111, LOAD = 7'b0000011;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req, we, ack, retire, trap;
    logic [31:0] addr, wdata, rdata, pc;
    logic [3:0]  wstrb;
    logic [1:0]  cause;

    logic        z_req, z_we, z_retire, z_trap;
    logic [31:0] z_addr, z_wdata, z_pc;
    logic [31:0] z_rdata = 32'h0220_8033;
    logic [3:0]  z_wstrb;
    logic [1:0]  z_cause;

    logic [31:0] mem [0:255];
    int          wait_n = 0, cnt = 0;
    logic        force_ack = 1'b0, pl_we = 1'b0;
    logic [31:0] pl_addr = 32'b0, pl_data = 32'b0;
    logic [31:0] last_waddr = 32'b0, last_wdata = 32'b0;
    logic [3:0]  last_wstrb = 4'b0;

    int          cyc = 0, nret = 0, wreq_cyc = 0;
    int          ret_cyc [0:127];
    logic [31:0] ret_pc  [0:127];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    cpu_multicycle #(.RESET_PC(32'h0000_0080), .EXTM(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_req(req), .o_we(we), .o_addr(addr),
        .o_wdata(wdata), .o_wstrb(wstrb), .i_ack(ack), .i_rdata(rdata), .o_pc(pc),
        .o_retire(retire), .o_trap(trap), .o_trap_cause(cause)
    );

    cpu_multicycle dut_nom (
        .i_clk(clk), .i_rst_n(rst_n), .o_req(z_req), .o_we(z_we), .o_addr(z_addr),
        .o_wdata(z_wdata), .o_wstrb(z_wstrb), .i_ack(z_req), .i_rdata(z_rdata), .o_pc(z_pc),
        .o_retire(z_retire), .o_trap(z_trap), .o_trap_cause(z_cause)
    );

    assign ack   = force_ack || (req && cnt >= wait_n);
    assign rdata = mem[addr[9:2]];

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr[9:2]] <= pl_data;
        end else if (req && ack && we) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[addr[9:2]][b*8 +: 8] <= wdata[b*8 +: 8];
            last_waddr <= addr;
            last_wstrb <= wstrb;
            last_wdata <= wdata;
        end
        if (req && !ack) cnt <= cnt + 1;
        else             cnt <= 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (retire && nret < 128) begin
            ret_cyc[nret] = cyc;
            ret_pc[nret]  = pc;
            nret = nret + 1;
        end
        if (req && we) wreq_cyc = wreq_cyc + 1;
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        step();
        pl_we   = 1'b0;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        step();
    endtask

    task automatic run_to_trap(input string tag);
        int n;
        n = 0;
        while (trap !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk(tag, {31'b0, trap}, 32'd1);
    endtask

    initial begin
        int b, w, seen;

        // reset state
        step();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_pc", pc, 32'h80);
        chk("rst_addr", addr, 32'h0);
        chk("rst_outs", {24'b0, retire, trap, cause, wstrb}, 32'h0);

        // ADDI / ADD, zero wait
        poke(32'h80, enc_i(5, 0, 0, 1, OPI));
        poke(32'h84, enc_r(0, 1, 1, 0, 2));
        poke(32'h88, enc_s(32'h200, 2, 0, 2));
        poke(32'h8C, EBREAK);
        poke(32'h200, 32'h0);
        wait_n = 0;
        b = nret;
        rst_n = 1'b1;
        #1;
        chk("first_fetch_req", {31'b0, req}, 32'd1);
        chk("first_fetch_addr", addr, 32'h80);
        run_to_trap("t1_halt");
        chk("add_result", peek(32'h200), 32'd10);
        chk("retire_gap", ret_cyc[b+1] - ret_cyc[b], 32'd4);
        chk("retire_pc0", ret_pc[b], 32'h80);
        chk("retire_pc1", ret_pc[b+1], 32'h84);
        chk("retire_pc2", ret_pc[b+2], 32'h88);
        chk("ebreak_cause", {30'b0, cause}, 32'd3);
        chk("ebreak_pc", pc, 32'h8C);
        chk("nom_mul_trap", {31'b0, z_trap}, 32'd1);
        chk("nom_mul_cause", {30'b0, z_cause}, 32'd0);
        chk("nom_mul_pc", z_pc, 32'h0);

        // SB with 3 wait states
        hold_reset();
        poke(32'h80, enc_u(32'h12345, 1, LUI));
        poke(32'h84, enc_i(32'h678, 1, 0, 1, OPI));
        poke(32'h88, enc_s(32'h103, 1, 0, 0));
        poke(32'h8C, EBREAK);
        poke(32'h100, 32'h0);
        wait_n = 3;
        w = wreq_cyc;
        rst_n = 1'b1;
        run_to_trap("sb_halt");
        chk("sb_addr", last_waddr, 32'h100);
        chk("sb_wstrb", {28'b0, last_wstrb}, 32'h8);
        chk("sb_wdata", last_wdata, 32'h7878_7878);
        chk("sb_req_hold", wreq_cyc - w, 32'd4);
        chk("sb_mem", peek(32'h100), 32'h7800_0000);

        // LBU / LB sign handling, zero wait
        hold_reset();
        poke(32'h80, enc_i(32'h103, 0, 4, 3, LOAD));
        poke(32'h84, enc_i(32'h103, 0, 0, 4, LOAD));
        poke(32'h88, enc_s(32'h200, 3, 0, 2));
        poke(32'h8C, enc_s(32'h204, 4, 0, 2));
        poke(32'h90, EBREAK);
        poke(32'h100, 32'h8000_0000);
        wait_n = 0;
        b = nret;
        rst_n = 1'b1;
        run_to_trap("load_halt");
        chk("lbu_val", peek(32'h200), 32'h80);
        chk("lb_val", peek(32'h204), 32'hFFFF_FF80);
        chk("load_latency", ret_cyc[b+1] - ret_cyc[b], 32'd5);

        // misaligned LW
        hold_reset();
        poke(32'h80, enc_i(7, 0, 0, 5, OPI));
        poke(32'h84, enc_i(32'h102, 0, 2, 5, LOAD));
        poke(32'h88, EBREAK);
        b = nret;
        rst_n = 1'b1;
        run_to_trap("lw_halt");
        chk("lw_cause", {30'b0, cause}, 32'd1);
        chk("lw_pc", pc, 32'h84);
        chk("lw_rd_kept", dut.rf[5], 32'd7);
        seen = 0;
        repeat (6) begin
            step();
            if (req) seen++;
            if (retire) seen++;
        end
        chk("lw_quiet", seen, 32'd0);
        chk("lw_retires", nret - b, 32'd1);

        // M extension corner cases
        hold_reset();
        poke(32'h80, enc_i(7, 0, 0, 1, OPI));
        poke(32'h84, enc_r(1, 0, 1, 4, 2));
        poke(32'h88, enc_u(32'h80000, 3, LUI));
        poke(32'h8C, enc_i(-1, 0, 0, 4, OPI));
        poke(32'h90, enc_r(1, 4, 3, 6, 5));
        poke(32'h94, enc_r(1, 4, 3, 4, 6));
        poke(32'h98, enc_r(1, 0, 1, 6, 7));
        poke(32'h9C, enc_r(1, 4, 1, 0, 8));
        poke(32'hA0, enc_s(32'h200, 2, 0, 2));
        poke(32'hA4, enc_s(32'h204, 5, 0, 2));
        poke(32'hA8, enc_s(32'h208, 6, 0, 2));
        poke(32'hAC, enc_s(32'h20C, 7, 0, 2));
        poke(32'hB0, enc_s(32'h210, 8, 0, 2));
        poke(32'hB4, EBREAK);
        poke(32'h204, 32'h1111_1111);
        rst_n = 1'b1;
        run_to_trap("m_halt");
        chk("div_by_zero", peek(32'h200), 32'hFFFF_FFFF);
        chk("rem_overflow", peek(32'h204), 32'h0);
        chk("div_overflow", peek(32'h208), 32'h8000_0000);
        chk("rem_by_zero", peek(32'h20C), 32'd7);
        chk("mul_neg", peek(32'h210), 32'hFFFF_FFF9);

        // branches and JALR
        hold_reset();
        poke(32'h80, enc_b(8, 0, 0, 1));
        poke(32'h84, enc_i(32'h201, 0, 0, 1, OPI));
        poke(32'h88, enc_i(0, 1, 0, 2, JALR));
        poke(32'h200, enc_s(32'h300, 2, 0, 2));
        poke(32'h204, enc_b(6, 0, 0, 0));
        poke(32'h300, 32'h0);
        b = nret;
        rst_n = 1'b1;
        run_to_trap("br_halt");
        chk("bne_not_taken", ret_pc[b+1], 32'h84);
        chk("jalr_target", ret_pc[b+3], 32'h200);
        chk("jalr_link", peek(32'h300), 32'h8C);
        chk("beq_cause", {30'b0, cause}, 32'd2);
        chk("beq_pc", pc, 32'h204);

        // reset while a store is waiting
        hold_reset();
        poke(32'h80, enc_i(32'h55, 0, 0, 1, OPI));
        poke(32'h84, enc_s(32'h300, 1, 0, 2));
        poke(32'h88, EBREAK);
        poke(32'h300, 32'hDEAD_BEEF);
        wait_n = 3;
        rst_n = 1'b1;
        seen = 0;
        while (!(req && we) && seen < 100) begin
            step();
            seen++;
        end
        chk("mid_reach_store", {31'b0, req && we}, 32'd1);
        step();
        rst_n = 1'b0;
        force_ack = 1'b1;
        #1;
        chk("mid_req_drop", {31'b0, req}, 32'd0);
        chk("mid_wstrb_zero", {28'b0, wstrb}, 32'd0);
        step();
        step();
        chk("mid_no_write", peek(32'h300), 32'hDEAD_BEEF);
        force_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("restart_req", {31'b0, req}, 32'd1);
        chk("restart_addr", addr, 32'h80);
        run_to_trap("restart_halt");
        chk("restart_store", peek(32'h300), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle RV32I core for configurations where instruction and data memory share one bus with variable wait states. It replaces the single-cycle core's assumption of zero-latency fetch and load with a request/acknowledge handshake. It adds byte-lane strobes for sub-word stores and precise halting traps, and makes the M extension and reset vector build-time options. It sits between the top-level memory arbiter and the debug/test harness.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `EXTM`, default 0: 1 enables the RV32M MUL/DIV/REM group; 0 makes those encodings illegal.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `o_req` in/out: out 1: bus request, held until accepted.
- `o_we` out 1: 1 = write, 0 = read; valid while `o_req`.
- `o_addr` out 32: word-aligned byte address, low two bits always 0.
- `o_wdata` out 32: store data, lane-replicated.
- `o_wstrb` out 4: byte-lane write enables; 0 on reads.
- `i_ack` in 1: transfer completes on a rising edge where `o_req && i_ack`.
- `i_rdata` in 32: read data, sampled on the completing edge.
- `o_pc` out 32: PC of the instruction currently in flight.
- `o_retire` out 1: one-cycle pulse per completed instruction.
- `o_trap` out 1: sticky; the core has halted.
- `o_trap_cause` out 2: 0 illegal instruction, 1 misaligned load/store, 2 misaligned jump/branch target, 3 ECALL/EBREAK.

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives `o_req`=1, `o_we`=0, `o_addr`=pc.
  - On accept, latches the instruction into IR and moves to DECODE.
- DECODE:
  - Reads rs1 and rs2 into operand registers.
  - Checks the opcode. An illegal opcode, or M-group encodings when EXTM=0, go to HALT with cause 0.
  - ECALL/EBREAK go to HALT with cause 3.
  - FENCE executes as a NOP.
- EXEC:
  - Computes the ALU/M result, the branch decision and the target, and latches them.
  - A load/store with a misaligned effective address goes to HALT with cause 1. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A taken branch, JAL or JALR whose target has [1:0]≠0 goes to HALT with cause 2. The JALR target clears bit 0 before this check.
  - Loads and stores go to MEM; all other instructions go to WB.
- MEM:
  - Holds one bus transaction until accepted, then goes to WB.
  - Store byte: `o_wstrb` = 1<<addr[1:0], `o_wdata` = {4{rs2[7:0]}}.
  - Store half: `o_wstrb` = 0011 or 1100, `o_wdata` = {2{rs2[15:0]}}.
  - Store word: `o_wstrb` = 1111, `o_wdata` = rs2.
  - Loads latch the lane selected by addr[1:0], sign- or zero-extended per funct3.
- WB:
  - Writes rd when rd≠0. x0 reads as 0 always.
  - Updates pc to the target or to pc+4. JAL/JALR write pc+4 to rd.
  - Pulses `o_retire` and goes to FETCH.
- HALT:
  - `o_trap`=1. `o_trap_cause` holds its value and `o_pc` holds the faulting PC.
  - `o_req`=0. Nothing is written to registers and pc does not change.
  - Only reset leaves HALT.
- M-unit results (EXTM=1):
  - Divide by zero gives quotient 32'hFFFF_FFFF and remainder = dividend.
  - 32'h8000_0000 / −1 gives quotient 32'h8000_0000 and remainder 0.
- Reset values (asynchronous):
  - Zero: `o_req`, `o_we`, `o_addr`, `o_wdata`, `o_wstrb`, `o_retire`, `o_trap`, `o_trap_cause`.
  - `o_pc` = `RESET_PC`. Registers x1–x31 = 0. State = FETCH.

## Timing
- Bus handshake:
  - `o_addr`, `o_we`, `o_wdata` and `o_wstrb` are stable while `o_req`=1 and not yet accepted.
  - `o_req` deasserts in the cycle after acceptance; there are no back-to-back requests.
  - `i_ack` while `o_req`=0 is ignored.
- Zero-wait latencies (ack in the same cycle as req): ALU, branch and jump instructions take 4 cycles; loads and stores take 5. Each wait cycle adds 1.
- First cycle after `i_rst_n` rises: FETCH with `o_req`=1 and `o_addr`=`RESET_PC`.
- Reset mid-transaction: `o_req` drops combinationally-asynchronously with reset. The pending ack is discarded and no partial writeback occurs.
- `o_retire` is high exactly during the WB cycle. `o_pc` updates on the WB→FETCH edge.
- The trap is raised on the edge leaving DECODE or EXEC. `o_retire` does not pulse for the faulting instruction.

## Test plan
- ADDI x1,x0,5 then ADD x2,x1,x1 with zero-wait memory → x2=10; `o_retire` pulses 4 cycles apart; `o_pc` goes 0, 4, 8.
- SB x1 (=0x12345678) to 0x103 with 3 wait states → `o_addr`=0x100, `o_wstrb`=1000, `o_wdata`=0x78787878, `o_req` held 4 cycles; LBU from 0x103 with `i_rdata`=0x80000000 → rd=0x80; LB → 0xFFFFFF80.
- LW from 0x102 → `o_trap`=1, cause 1, `o_pc` = PC of the LW, rd unchanged, `o_req` stays 0.
- EXTM=0: MUL encoding 0x02208033 → trap cause 0. EXTM=1: DIV 7/0 → 0xFFFFFFFF; REM 0x80000000 % −1 → 0.
- BEQ x0,x0,+6 → cause 2. BNE on equal operands → not taken, pc+4. JALR target 0x201 → pc 0x200, rd = old pc+4.
- Assert `i_rst_n`=0 mid-MEM, with a store pending and `i_ack` arriving → no write is accepted, `o_req`=0 immediately. After release the first fetch is at `RESET_PC` (e.g. 0x80).
